// File: rtl/kmeans_pkg.sv
// Shared constants, state encoding and job helpers for the k-means centroid update block.
package kmeans_pkg;

    localparam int K       = 3;
    localparam int COORD_W = 8;
    localparam int SUM_W   = 16;
    localparam int CNT_W   = 5;

    // One division job per coordinate of every cluster.
    localparam int N_JOBS = K * 3;
    localparam int JOB_W  = 4;

    // Largest value a centroid coordinate can hold; quotients above it clamp here.
    localparam int SAT = (1 << COORD_W) - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        DIV   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Jobs run x,y,z of cluster 0, then cluster 1, then cluster 2.
    function automatic logic [1:0] job_cluster(input logic [JOB_W-1:0] job);
        if (job < JOB_W'(3)) begin
            return 2'd0;
        end else if (job < JOB_W'(6)) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage

// File: rtl/kmeans_seq_div.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// D_W sets both the dividend width and the number of iterations.
module kmeans_seq_div
    import kmeans_pkg::*;
#(
    parameter int D_W = 16,
    parameter int V_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [D_W-1:0] dividend,
    input  logic [V_W-1:0] divisor,
    output logic [D_W-1:0] quotient,
    output logic           done
);

    localparam int CW = (D_W > 1) ? $clog2(D_W) : 1;

    logic [D_W-1:0] quo;
    logic [V_W-1:0] rem;
    logic [V_W-1:0] dvs;
    logic [CW-1:0]  bit_cnt;
    logic           run;
    logic [V_W:0]   shifted;
    logic           fits;

    // Trial subtraction of the divisor from the partial remainder plus the next dividend bit.
    always_comb begin
        shifted = {rem, quo[D_W-1]};
        fits    = (shifted >= {1'b0, dvs});
    end

    // Load operands, then shift one quotient bit into the low end of quo per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            bit_cnt <= '0;
            run     <= 1'b0;
        end else if (load) begin
            quo     <= dividend;
            rem     <= '0;
            dvs     <= divisor;
            bit_cnt <= CW'(D_W - 1);
            run     <= 1'b1;
        end else if (run) begin
            rem     <= fits ? V_W'(shifted - {1'b0, dvs}) : V_W'(shifted);
            quo     <= {quo[D_W-2:0], fits};
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == '0) begin
                run <= 1'b0;
            end
        end
    end

    assign quotient = quo;
    // High during the final iteration; quotient is complete after this edge.
    assign done     = run && (bit_cnt == '0);

endmodule

// File: rtl/kmeans_centroid_update.sv
// K-means centroid update: snapshots per-cluster sums/counts, divides each of the
// nine coordinates with a shared sequential divider and publishes all centroids at once.
// Optional build macro KMEANS_CU_ROUND_EN: round-half-up (dividend = sum + cnt/2,
// one extra divide cycle per job). Undefined: truncation toward zero.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last published centroids
// SETUP | select operands for job k, launch divider or skip an empty cluster
// DIV   | divider iterating, one quotient bit per cycle
// WRITE | saturate quotient into shadow coordinate k, advance k
// DONE  | copy shadow coordinates to outputs, pulse cent_valid
module kmeans_centroid_update #(
    parameter int                     SUM_W   = 16,
    parameter int                     CNT_W   = 5,
    parameter int                     COORD_W = 8,
    parameter logic [3*COORD_W-1:0]   C0_INIT = 24'h202020,
    parameter logic [3*COORD_W-1:0]   C1_INIT = 24'h808080,
    parameter logic [3*COORD_W-1:0]   C2_INIT = 24'hE0E0E0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SUM_W-1:0]     sumx0,
    input  logic [SUM_W-1:0]     sumy0,
    input  logic [SUM_W-1:0]     sumz0,
    input  logic [SUM_W-1:0]     sumx1,
    input  logic [SUM_W-1:0]     sumy1,
    input  logic [SUM_W-1:0]     sumz1,
    input  logic [SUM_W-1:0]     sumx2,
    input  logic [SUM_W-1:0]     sumy2,
    input  logic [SUM_W-1:0]     sumz2,
    input  logic [CNT_W-1:0]     cnt0,
    input  logic [CNT_W-1:0]     cnt1,
    input  logic [CNT_W-1:0]     cnt2,
    output logic [3*COORD_W-1:0] cent0,
    output logic [3*COORD_W-1:0] cent1,
    output logic [3*COORD_W-1:0] cent2,
    output logic                 busy,
    output logic                 cent_valid
);

    import kmeans_pkg::*;

`ifdef KMEANS_CU_ROUND_EN
    localparam int DIV_W = SUM_W + 1;
`else
    localparam int DIV_W = SUM_W;
`endif

    localparam logic [DIV_W-1:0] QUO_MAX = DIV_W'((1 << COORD_W) - 1);
    localparam logic [N_JOBS*COORD_W-1:0] INIT_ALL = {C0_INIT, C1_INIT, C2_INIT};

    state_t                    state;
    logic [JOB_W-1:0]          job;
    logic [N_JOBS*SUM_W-1:0]   sum_q;
    logic [K*CNT_W-1:0]        cnt_q;
    logic [N_JOBS*COORD_W-1:0] shadow;

    logic [SUM_W-1:0]   sum_sel;
    logic [CNT_W-1:0]   cnt_sel;
    logic [DIV_W-1:0]   dividend;
    logic [DIV_W-1:0]   quotient;
    logic [COORD_W-1:0] coord_new;
    logic               div_load;
    logic               div_done;

    // Operand select for the current job; job 0 sits in the MSBs of the packed snapshots.
    always_comb begin
        sum_sel   = sum_q[(N_JOBS - 1 - int'(job)) * SUM_W +: SUM_W];
        cnt_sel   = cnt_q[(K - 1 - int'(job_cluster(job))) * CNT_W +: CNT_W];
        coord_new = (quotient > QUO_MAX) ? QUO_MAX[COORD_W-1:0] : quotient[COORD_W-1:0];
        div_load  = (state == SETUP) && (cnt_sel != '0);
    end

`ifdef KMEANS_CU_ROUND_EN
    assign dividend = {1'b0, sum_sel} + DIV_W'(cnt_sel >> 1);
`else
    assign dividend = sum_sel;
`endif

    kmeans_seq_div #(
        .D_W (DIV_W),
        .V_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend (dividend),
        .divisor  (cnt_sel),
        .quotient (quotient),
        .done     (div_done)
    );

    // Sequencing FSM with registered outputs; outputs only move in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            job        <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            shadow     <= INIT_ALL;
            cent0      <= C0_INIT;
            cent1      <= C1_INIT;
            cent2      <= C2_INIT;
            busy       <= 1'b0;
            cent_valid <= 1'b0;
        end else begin
            cent_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sum_q <= {sumx0, sumy0, sumz0, sumx1, sumy1, sumz1, sumx2, sumy2, sumz2};
                        cnt_q <= {cnt0, cnt1, cnt2};
                        job   <= '0;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    // An empty cluster keeps its previously published coordinate.
                    state <= (cnt_sel == '0) ? WRITE : DIV;
                end
                DIV: begin
                    if (div_done) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (cnt_sel != '0) begin
                        shadow[(N_JOBS - 1 - int'(job)) * COORD_W +: COORD_W] <= coord_new;
                    end
                    if (job == JOB_W'(N_JOBS - 1)) begin
                        state <= DONE;
                    end else begin
                        job   <= job + 1'b1;
                        state <= SETUP;
                    end
                end
                DONE: begin
                    {cent0, cent1, cent2} <= shadow;
                    cent_valid            <= 1'b1;
                    busy                  <= 1'b0;
                    state                 <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Scoreboard bench for kmeans_centroid_update: stimulus pushes expected centroids and
// latency; a monitor pops and compares whenever cent_valid is seen.
// Honours KMEANS_CU_ROUND_EN for rounding and latency expectations.
module tb_kmeans_centroid_update;

`ifdef KMEANS_CU_ROUND_EN
    localparam int         DIV_LEN = 17;
    localparam logic [7:0] X0_ODD  = 8'd3;
`else
    localparam int         DIV_LEN = 16;
    localparam logic [7:0] X0_ODD  = 8'd2;
`endif
    localparam int LAT_FULL     = 9 * (DIV_LEN + 2) + 1;
    localparam int LAT_ONE_ZERO = LAT_FULL - 3 * DIV_LEN;

    localparam logic [23:0] INIT0 = 24'h202020;
    localparam logic [23:0] INIT1 = 24'h808080;
    localparam logic [23:0] INIT2 = 24'hE0E0E0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] sum_v [9];
    logic [4:0]  cnt_v [3];
    logic [23:0] cent0, cent1, cent2;
    logic        busy, cent_valid;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [23:0] e0;
        logic [23:0] e1;
        logic [23:0] e2;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    kmeans_centroid_update dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sumx0      (sum_v[0]),
        .sumy0      (sum_v[1]),
        .sumz0      (sum_v[2]),
        .sumx1      (sum_v[3]),
        .sumy1      (sum_v[4]),
        .sumz1      (sum_v[5]),
        .sumx2      (sum_v[6]),
        .sumy2      (sum_v[7]),
        .sumz2      (sum_v[8]),
        .cnt0       (cnt_v[0]),
        .cnt1       (cnt_v[1]),
        .cnt2       (cnt_v[2]),
        .cent0      (cent0),
        .cent1      (cent1),
        .cent2      (cent2),
        .busy       (busy),
        .cent_valid (cent_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_cluster(input int c, input int x, input int y, input int z, input int n);
        sum_v[3*c]     = 16'(x);
        sum_v[3*c + 1] = 16'(y);
        sum_v[3*c + 2] = 16'(z);
        cnt_v[c]       = 5'(n);
    endtask

    task automatic set_base();
        set_cluster(0, 100, 50, 30, 10);
        set_cluster(1, 600, 300, 450, 3);
        set_cluster(2, 5100, 5100, 5100, 20);
    endtask

    // Issue one start, push the expected result, then watch until cent_valid:
    // before it, outputs must hold their previous values and busy must stay high.
    task automatic run(input string name, input logic [23:0] e0, input logic [23:0] e1,
                       input logic [23:0] e2, input int lat, input bit repulse);
        int          s;
        bit          seen;
        bit          hold_bad;
        logic [23:0] p0, p1, p2;
        seen = 1'b0;
        hold_bad = 1'b0;
        p0 = cent0;
        p1 = cent1;
        p2 = cent2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b0;
        sb.push_back('{e0, e1, e2, s, lat});
        for (int n = 1; n <= lat + 20 && !seen; n++) begin
            @(negedge clk);
            if (cent_valid) begin
                seen = 1'b1;
            end else if (cent0 !== p0 || cent1 !== p1 || cent2 !== p2 || busy !== 1'b1) begin
                hold_bad = 1'b1;
            end
            if (repulse && (cyc - s == 19 || cyc - s == 99)) begin
                set_cluster(0, 1000, 1000, 1000, 1);
                set_cluster(1, 1000, 1000, 1000, 1);
                set_cluster(2, 1000, 1000, 1000, 1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({"seen_", name}, 32'(seen), 32'd1);
        check({"hold_", name}, 32'(hold_bad), 32'd0);
    endtask

    // Monitor: compare every published result against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && cent_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pulse at cycle %0d want none", cyc);
            end else begin
                e = sb.pop_front();
                check("cent0", 32'(cent0), 32'(e.e0));
                check("cent1", 32'(cent1), 32'(e.e1));
                check("cent2", 32'(cent2), 32'(e.e2));
                check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                check("busy_at_valid", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit bad;
        int s;
        set_base();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_cent0", 32'(cent0), 32'(INIT0));
        check("rst_cent1", 32'(cent1), 32'(INIT1));
        check("rst_cent2", 32'(cent2), 32'(INIT2));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(cent_valid), 32'd0);
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (cent0 !== INIT0 || cent1 !== INIT1 || cent2 !== INIT2 || busy !== 1'b0 || cent_valid !== 1'b0)
                bad = 1'b1;
        end
        check("idle_hold", 32'(bad), 32'd0);

        // Basic division plus saturation of cluster 2.
        set_base();
        run("base", 24'h0A0503, 24'hC86496, 24'hFFFFFF, LAT_FULL, 1'b0);

        // Empty cluster 1 keeps its previous centroid and shortens latency.
        set_base();
        set_cluster(1, 600, 300, 450, 0);
        run("zero_cnt1", 24'h0A0503, 24'hC86496, 24'hFFFFFF, LAT_ONE_ZERO, 1'b0);

        // Rounding-sensitive x0 and a single saturating coordinate.
        set_base();
        set_cluster(0, 29, 50, 30, 10);
        set_cluster(1, 600, 300, 900, 3);
        run("round_sat", {X0_ODD, 8'd5, 8'd3}, 24'hC864FF, 24'hFFFFFF, LAT_FULL, 1'b0);

        // Extra starts while busy must be ignored.
        set_cluster(0, 70, 80, 90, 10);
        set_cluster(1, 3, 6, 9, 3);
        set_cluster(2, 40, 60, 80, 20);
        run("repulse", 24'h070809, 24'h010203, 24'h020304, LAT_FULL, 1'b1);

        // Reset mid-computation aborts with no pulse.
        set_base();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b0;
        while (cyc - s < 49) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cent0", 32'(cent0), 32'(INIT0));
        check("abort_cent1", 32'(cent1), 32'(INIT1));
        check("abort_cent2", 32'(cent2), 32'(INIT2));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(cent_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);

        set_base();
        run("after_abort", 24'h0A0503, 24'hC86496, 24'hFFFFFF, LAT_FULL, 1'b0);

        repeat (10) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
